// File: rtl/huffman_dec.sv
// Huffman prefix-code decoder: consumes MSB-first packed words, matches the
// buffered bits against a runtime-loadable code table and emits one symbol
// per cycle. Optional macro HUFF_DEC_STATS_EN adds saturating symbol/error
// counters as extra output ports.
module huffman_dec #(
  parameter int unsigned W = 8,
  parameter int unsigned C = 4,
  parameter int unsigned N = 16,
  parameter int unsigned S = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         d_in,
  input  logic                 en_in,
  output logic                 ready_out,
  input  logic                 flush,
  input  logic                 tbl_we,
  input  logic [$clog2(N)-1:0] tbl_addr,
  input  logic [W-1:0]         tbl_code,
  input  logic [C-1:0]         tbl_len,
  input  logic [S-1:0]         tbl_sym,
  output logic [S-1:0]         sym_out,
  output logic                 en_out,
`ifdef HUFF_DEC_STATS_EN
  output logic [15:0]          sym_cnt,
  output logic [7:0]           err_cnt,
`endif
  output logic                 err_out
);

  localparam int unsigned BW = 2 * W;
  localparam int unsigned CW = $clog2(BW + 1);

  logic [BW-1:0] acc;
  logic [CW-1:0] cnt;

  logic [W-1:0] tcode [N];
  logic [C-1:0] tlen  [N];
  logic [S-1:0] tsym  [N];

  logic          hit;
  logic [C-1:0]  hit_len;
  logic [S-1:0]  hit_sym;
  logic [W-1:0]  mask;
  logic          err_c;
  logic [BW-1:0] acc_b;
  logic [CW-1:0] cnt_b;
  logic [BW-1:0] acc_n;
  logic [CW-1:0] cnt_n;

  // Code table storage; a reset invalidates every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) begin
        tcode[i] <= '0;
        tlen[i]  <= '0;
        tsym[i]  <= '0;
      end
    end else if (tbl_we) begin
      tcode[tbl_addr] <= tbl_code;
      tlen[tbl_addr]  <= tbl_len;
      tsym[tbl_addr]  <= tbl_sym;
    end
  end

  // Prefix match against the head of the buffer; the descending scan lets the lowest index win.
  always_comb begin
    hit     = 1'b0;
    hit_len = '0;
    hit_sym = '0;
    mask    = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      mask = ~({W{1'b1}} >> tlen[i]);
      if ((tlen[i] != '0) && (32'(tlen[i]) <= W) && (32'(tlen[i]) <= 32'(cnt)) &&
          (((acc[BW-1 -: W] ^ tcode[i]) & mask) == '0)) begin
        hit     = 1'b1;
        hit_len = tlen[i];
        hit_sym = tsym[i];
      end
    end
  end

  // Buffer update: consume the matched code (or discard on error), then append an accepted word.
  always_comb begin
    ready_out = !flush && (cnt <= CW'(W));
    err_c     = !hit && (cnt >= CW'(W));
    if (err_c) begin
      acc_b = '0;
      cnt_b = '0;
    end else begin
      acc_b = acc << hit_len;
      cnt_b = cnt - CW'(hit_len);
    end
    acc_n = acc_b;
    cnt_n = cnt_b;
    if (en_in && ready_out) begin
      acc_n = acc_b | ({d_in, {W{1'b0}}} >> cnt_b);
      cnt_n = cnt_b + CW'(W);
    end
  end

  // Bit buffer and registered decode outputs; flush empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      sym_out <= '0;
      en_out  <= 1'b0;
      err_out <= 1'b0;
    end else if (flush) begin
      acc     <= '0;
      cnt     <= '0;
      en_out  <= 1'b0;
      err_out <= 1'b0;
    end else begin
      acc     <= acc_n;
      cnt     <= cnt_n;
      en_out  <= hit;
      err_out <= err_c;
      if (hit) sym_out <= hit_sym;
    end
  end

`ifdef HUFF_DEC_STATS_EN
  // Saturating pulse counters, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (en_out && (sym_cnt != 16'hFFFF)) sym_cnt <= sym_cnt + 16'd1;
      if (err_out && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_huffman_dec.sv
// Self-checking bench for huffman_dec: directed steps with a symbol scoreboard.
module tb_huffman_dec;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d_in;
  logic       en_in;
  logic       ready_out;
  logic       flush;
  logic       tbl_we;
  logic [3:0] tbl_addr;
  logic [7:0] tbl_code;
  logic [3:0] tbl_len;
  logic [7:0] tbl_sym;
  logic [7:0] sym_out;
  logic       en_out;
  logic       err_out;
`ifdef HUFF_DEC_STATS_EN
  logic [15:0] sym_cnt;
  logic [7:0]  err_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int stalls   = 0;

  // Expected outputs: {en, err, sym}
  logic [9:0] q[$];

  huffman_dec dut (
    .clk       (clk),
    .rst       (rst),
    .d_in      (d_in),
    .en_in     (en_in),
    .ready_out (ready_out),
    .flush     (flush),
    .tbl_we    (tbl_we),
    .tbl_addr  (tbl_addr),
    .tbl_code  (tbl_code),
    .tbl_len   (tbl_len),
    .tbl_sym   (tbl_sym),
    .sym_out   (sym_out),
    .en_out    (en_out),
`ifdef HUFF_DEC_STATS_EN
    .sym_cnt   (sym_cnt),
    .err_cnt   (err_cnt),
`endif
    .err_out   (err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_sym(input logic [7:0] s);
    q.push_back({1'b1, 1'b0, s});
  endtask

  task automatic push_err();
    q.push_back({1'b0, 1'b1, 8'h00});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
  endtask

  task automatic tbl_write(input logic [3:0] a, input logic [7:0] code,
                           input logic [3:0] len, input logic [7:0] s);
    @(negedge clk);
    tbl_we   = 1'b1;
    tbl_addr = a;
    tbl_code = code;
    tbl_len  = len;
    tbl_sym  = s;
    @(negedge clk);
    tbl_we   = 1'b0;
  endtask

  // Offer a word until accepted (bounded); returns just after the accepting edge.
  task automatic send_word(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      en_in = 1'b1;
      d_in  = b;
      ok    = ready_out;
      if (!ok) stalls++;
      @(posedge clk);
    end
    #1 en_in = 1'b0;
    check("accept", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    check("drain", 32'(q.size()), 32'd0);
  endtask

  // Scoreboard monitor: every output pulse must match the head of the queue.
  initial begin
    logic [9:0] obs;
    forever begin
      @(posedge clk);
      #1;
      if (en_out || err_out) begin
        obs = {en_out, err_out, en_out ? sym_out : 8'h00};
        if (q.size() == 0) check("unexpected_output", 32'(obs), 32'd0);
        else check("scoreboard", 32'(obs), 32'(q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en_in = 1'b0; d_in = '0; flush = 1'b0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_code = '0; tbl_len = '0; tbl_sym = '0;
    #1;
    check("rst_sym", 32'(sym_out), 32'd0);
    check("rst_en", 32'(en_out), 32'd0);
    check("rst_err", 32'(err_out), 32'd0);
    check("rst_ready", 32'(ready_out), 32'd1);
    do_reset();

    // Three-entry table, 0x5B -> 41 42 43 41 43 on consecutive cycles
    tbl_write(4'd0, 8'h00, 4'd1, 8'h41);
    tbl_write(4'd1, 8'h80, 4'd2, 8'h42);
    tbl_write(4'd2, 8'hC0, 4'd2, 8'h43);
    push_sym(8'h41); push_sym(8'h42); push_sym(8'h43); push_sym(8'h41); push_sym(8'h43);
    send_word(8'h5B);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      check("t1_en_consecutive", 32'(en_out), 32'd1);
    end
    @(posedge clk); #2;
    check("t1_en_done", 32'(en_out), 32'd0);
    drain();

    // Code spanning a word boundary
    do_reset();
    tbl_write(4'd0, 8'h00, 4'd1, 8'h00);
    tbl_write(4'd1, 8'hA0, 4'd3, 8'h05);
    for (int i = 0; i < 6; i++) push_sym(8'h00);
    push_sym(8'h05);
    for (int i = 0; i < 7; i++) push_sym(8'h00);
    send_word(8'h02);
    send_word(8'h80);
    drain();

    // No match on a full word -> one error pulse one edge after accept
    do_reset();
    tbl_write(4'd0, 8'h00, 4'd1, 8'h00);
    push_err();
    send_word(8'hFF);
    @(posedge clk); #2;
    check("t3_err_pulse", 32'(err_out), 32'd1);
    check("t3_no_en", 32'(en_out), 32'd0);
    @(posedge clk); #2;
    check("t3_err_single", 32'(err_out), 32'd0);
    drain();

    // Back-to-back words with backpressure
    do_reset();
    tbl_write(4'd0, 8'h00, 4'd1, 8'h30);
    tbl_write(4'd1, 8'h80, 4'd1, 8'h31);
    stalls = 0;
    begin
      logic [7:0] words [4];
      logic [7:0] w;
      words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hF0; words[3] = 8'h0F;
      for (int k = 0; k < 4; k++) begin
        w = words[k];
        for (int b = 7; b >= 0; b--) push_sym(w[b] ? 8'h31 : 8'h30);
      end
      for (int k = 0; k < 4; k++) send_word(words[k]);
    end
    check("t4_backpressure", 32'(stalls > 0), 32'd1);
    drain();

    // Lowest index wins
    do_reset();
    tbl_write(4'd0, 8'h80, 4'd1, 8'h11);
    tbl_write(4'd3, 8'h80, 4'd2, 8'h22);
    push_sym(8'h11);
    send_word(8'h80);
    drain();

    // Flush with a word offered: buffer emptied, byte ignored
    @(negedge clk);
    flush = 1'b1;
    en_in = 1'b1;
    d_in  = 8'hFF;
    #1;
    check("flush_ready", 32'(ready_out), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    en_in = 1'b0;
    check("flush_en", 32'(en_out), 32'd0);
    check("flush_err", 32'(err_out), 32'd0);
    push_sym(8'h11);
    send_word(8'h80);
    drain();

    // Asynchronous reset mid-stream
    do_reset();
    tbl_write(4'd0, 8'h00, 4'd1, 8'h5A);
    for (int i = 0; i < 8; i++) push_sym(8'h5A);
    send_word(8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    check("pre_rst_en", 32'(en_out), 32'd1);
    rst = 1'b1;
    q.delete();
    #1;
    check("arst_sym", 32'(sym_out), 32'd0);
    check("arst_en", 32'(en_out), 32'd0);
    check("arst_err", 32'(err_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push_err();
    send_word(8'hFF);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
